vic_line_capture: RTL and testbench

- Receiving end of the VIC-II video output: consumes the 8 MHz pixel stream (24-bit RGB, hsync, vsync) and crops a configurable visible window.
- Each cropped line is buffered in a ping-pong line buffer, converted to RGB565, and re-emitted on the clk domain as a valid/ready stream with line and frame markers.
- Sits between the video generator and downstream display or framebuffer writers (LCD/SPI/HDMI packers).

---
 rtl/vic_line_capture.sv | 210 +++++++++++++++++++++
 tb/tb_vic_line_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_line_capture.sv
// vic_line_capture: crops a window out of the VIC-II pixel stream, buffers each
// cropped line in a ping-pong RAM as RGB565 and replays it on clk as a
// valid/ready stream with line (tlast) and frame (tuser) markers.
module vic_line_capture #(
  parameter int unsigned P_H_START  = 120,
  parameter int unsigned P_H_WIDTH  = 384,
  parameter int unsigned P_V_START  = 16,
  parameter int unsigned P_V_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pix_en,
  input  logic [23:0] i_pixel,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [15:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic [8:0]  o_line,
  output logic        o_overflow
);

  // Window bounds held one bit wider so START+WIDTH cannot wrap.
  localparam logic [9:0] H_FIRST = 10'(P_H_START);
  localparam logic [9:0] H_END   = 10'(P_H_START + P_H_WIDTH);
  localparam logic [9:0] V_FIRST = 10'(P_V_START);
  localparam logic [9:0] V_END   = 10'(P_V_START + P_V_HEIGHT);
  localparam logic [8:0] H_LAST  = 9'(P_H_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} rd_state_t;

  // Capture side
  logic [8:0]  h_cnt_reg, v_cnt_reg;
  logic [8:0]  h_cur, v_cur;
  logic        h_in, v_in, win;
  logic [8:0]  wr_addr, v_line;
  logic        wr_bank_reg;
  logic        line_ok_reg;
  logic        bank_avail, write_ok, wr_en, line_done, line_drop;
  logic [1:0]  full_reg, full_next;
  logic [8:0]  line_idx_reg [2];
  logic        overflow_reg;
  logic [15:0] pix565;
  logic        unused_pixel_bits;

  // Read side
  rd_state_t   state_reg;
  logic        rd_bank_reg;
  logic [8:0]  rd_addr_reg;
  logic        xfer, free_now, rd_en;
  logic [9:0]  rd_ram_addr;
  logic [15:0] rd_data_reg;
  logic        tvalid_reg, tlast_reg, tuser_reg;
  logic [8:0]  line_reg;

  logic [15:0] mem [0:1023];

  assign pix565 = {i_pixel[23:19], i_pixel[15:10], i_pixel[7:3]};
  // Truncated low colour bits are intentionally discarded.
  assign unused_pixel_bits = ^{i_pixel[18:16], i_pixel[9:8], i_pixel[2:0]};

  // Position of the pixel being presented: the hsync pixel is column 0 and
  // the vsync raster is line 0; both counters stick at 511.
  always_comb begin
    h_cur = (h_cnt_reg == 9'd511) ? h_cnt_reg : h_cnt_reg + 9'd1;
    v_cur = v_cnt_reg;
    if (i_hsync) begin
      h_cur = 9'd0;
      if (i_vsync) begin
        v_cur = 9'd0;
      end else if (v_cnt_reg != 9'd511) begin
        v_cur = v_cnt_reg + 9'd1;
      end
    end
  end

  assign h_in    = ({1'b0, h_cur} >= H_FIRST) && ({1'b0, h_cur} < H_END);
  assign v_in    = ({1'b0, v_cur} >= V_FIRST) && ({1'b0, v_cur} < V_END);
  assign win     = i_pix_en && h_in && v_in;
  assign wr_addr = 9'({1'b0, h_cur} - H_FIRST);
  assign v_line  = 9'({1'b0, v_cur} - V_FIRST);

  assign xfer     = tvalid_reg && i_tready;
  assign free_now = (state_reg == S_STREAM) && xfer && tlast_reg;

  // A line is accepted only if its bank is free when its first pixel lands
  // (a bank released in that very cycle counts as free). Once refused, the
  // whole line is refused so a half-written line can never be marked full.
  assign bank_avail = !full_reg[wr_bank_reg] || (free_now && (rd_bank_reg == wr_bank_reg));
  assign write_ok   = (wr_addr == 9'd0) ? bank_avail : line_ok_reg;
  assign wr_en      = win && write_ok;
  assign line_done  = win && (wr_addr == H_LAST) && write_ok;
  assign line_drop  = win && (wr_addr == H_LAST) && !write_ok;

  // Full flags: the reader frees its bank and the writer claims its own bank
  // in the same cycle without conflict because they are never the same bank.
  always_comb begin
    full_next = full_reg;
    if (free_now) begin
      full_next[rd_bank_reg] = 1'b0;
    end
    if (line_done) begin
      full_next[wr_bank_reg] = 1'b1;
    end
  end

  // Raster counters, bank ownership, line index latches and the drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= 9'd0;
      v_cnt_reg       <= 9'd0;
      wr_bank_reg     <= 1'b0;
      line_ok_reg     <= 1'b0;
      full_reg        <= 2'b00;
      line_idx_reg[0] <= 9'd0;
      line_idx_reg[1] <= 9'd0;
      overflow_reg    <= 1'b0;
    end else begin
      full_reg     <= full_next;
      overflow_reg <= line_drop;
      if (i_pix_en) begin
        h_cnt_reg <= h_cur;
        v_cnt_reg <= v_cur;
      end
      if (win && (wr_addr == 9'd0)) begin
        line_ok_reg <= bank_avail;
      end
      if (line_done) begin
        line_idx_reg[wr_bank_reg] <= v_line;
        wr_bank_reg               <= ~wr_bank_reg;
      end
    end
  end

  // Line buffer write port: both banks share one array, bank is the address MSB.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_reg, wr_addr}] <= pix565;
    end
  end

  // The read port advances only when priming or when the current beat is
  // taken, so the registered output doubles as the stalled tdata holder.
  assign rd_en       = (state_reg == S_PRIME) || ((state_reg == S_STREAM) && xfer && !tlast_reg);
  assign rd_ram_addr = (state_reg == S_PRIME) ? {rd_bank_reg, 9'd0}
                                              : {rd_bank_reg, rd_addr_reg + 9'd1};

  // Line buffer read port with registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= 16'd0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_ram_addr];
    end
  end

  // Reader FSM: pick a full bank, prime the RAM, stream one line of beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rd_bank_reg <= 1'b0;
      rd_addr_reg <= 9'd0;
      tvalid_reg  <= 1'b0;
      tlast_reg   <= 1'b0;
      tuser_reg   <= 1'b0;
      line_reg    <= 9'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|full_reg) begin
            rd_bank_reg <= !full_reg[0];
            state_reg   <= S_PRIME;
          end
        end
        S_PRIME: begin
          rd_addr_reg <= 9'd0;
          tvalid_reg  <= 1'b1;
          tlast_reg   <= (H_LAST == 9'd0);
          tuser_reg   <= (line_idx_reg[rd_bank_reg] == 9'd0);
          line_reg    <= line_idx_reg[rd_bank_reg];
          state_reg   <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            tuser_reg <= 1'b0;
            if (tlast_reg) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              state_reg  <= S_IDLE;
            end else begin
              rd_addr_reg <= rd_addr_reg + 9'd1;
              tlast_reg   <= ((rd_addr_reg + 9'd1) == H_LAST);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_tdata    = rd_data_reg;
  assign o_tvalid   = tvalid_reg;
  assign o_tlast    = tlast_reg;
  assign o_tuser    = tuser_reg;
  assign o_line     = line_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_vic_line_capture.sv
// Bench for vic_line_capture with a small 16x4 raster and an 8x2 window.
module tb_vic_line_capture;

  localparam int HS = 4;
  localparam int HW = 8;
  localparam int VS = 1;
  localparam int VH = 2;
  localparam int NH = 16;
  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pix_en;
  logic [23:0] i_pixel;
  logic        i_hsync;
  logic        i_vsync;
  logic [15:0] o_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tlast;
  logic        o_tuser;
  logic [8:0]  o_line;
  logic        o_overflow;

  vic_line_capture #(
    .P_H_START (HS),
    .P_H_WIDTH (HW),
    .P_V_START (VS),
    .P_V_HEIGHT(VH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_pix_en  (i_pix_en),
    .i_pixel   (i_pixel),
    .i_hsync   (i_hsync),
    .i_vsync   (i_vsync),
    .o_tdata   (o_tdata),
    .o_tvalid  (o_tvalid),
    .i_tready  (i_tready),
    .o_tlast   (o_tlast),
    .o_tuser   (o_tuser),
    .o_line    (o_line),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        user;
    logic [8:0]  line;
  } beat_t;

  beat_t exp_q[$];
  int    assert_cnt = 0;
  int    fail_cnt   = 0;
  int    ovf_cnt    = 0;
  int    beat_cnt   = 0;
  int    run_cnt    = 0;
  int    ready_mode = 0;   // 0: always ready, 1: held off, 2: toggle every clk
  bit    bubble_en  = 1'b0;
  bit    dr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [23:0] x);
    return {x[23:19], x[15:10], x[7:3]};
  endfunction

  function automatic logic [23:0] pix_of(input int mode, input int tag, input int v, input int h);
    logic [7:0] hb, vb, tb;
    hb = 8'(h);
    vb = 8'(v);
    tb = 8'(tag);
    case (mode)
      0:       return {hb, hb, hb};
      1:       return (v == 1) ? 24'hFF8040 : 24'h070307;
      default: return {hb[4:0], 3'b101, tb[3:0], vb[1:0], 2'b11, tb[4:0], 3'b011};
    endcase
  endfunction

  task automatic push_line(input int mode, input int tag, input int v);
    beat_t b;
    for (int k = 0; k < HW; k++) begin
      if (mode == 1) b.data = (v == 1) ? 16'hFC08 : 16'h0000;
      else           b.data = rgb565(pix_of(mode, tag, v, HS + k));
      b.last = (k == HW - 1);
      b.user = (v == VS) && (k == 0);
      b.line = 9'(v - VS);
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_tvalid"},   o_tvalid,   0);
    chk({pfx, "_tdata"},    o_tdata,    0);
    chk({pfx, "_tlast"},    o_tlast,    0);
    chk({pfx, "_tuser"},    o_tuser,    0);
    chk({pfx, "_line"},     o_line,     0);
    chk({pfx, "_overflow"}, o_overflow, 0);
  endtask

  // One pixel enable, then inputs return to idle.
  task automatic drive_pix(input bit hs, input bit vs, input logic [23:0] px);
    i_pix_en = 1'b1;
    i_hsync  = hs;
    i_vsync  = vs;
    i_pixel  = px;
    @(posedge clk);
    #1;
    i_pix_en = 1'b0;
    i_hsync  = 1'b0;
    i_vsync  = 1'b0;
  endtask

  task automatic drive_frame(input int mode, input int tag, input bit push, input bit lat_chk,
                             input bit arm_rst, output bit did_rst);
    bit lat_pt;
    did_rst = 1'b0;
    for (int v = 0; v < NV; v++) begin
      for (int h = 0; h < NH; h++) begin
        drive_pix(h == 0, (h == 0) && (v == 0), pix_of(mode, tag, v, h));
        lat_pt = lat_chk && (v == VS) && (h == HS + HW - 1);
        if (push && v >= VS && v < VS + VH && h == HS + HW - 1) push_line(mode, tag, v);
        if (lat_pt) chk("lat_e0", o_tvalid, 0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1;
          if (lat_pt && i < 2) chk((i == 0) ? "lat_e1" : "lat_e2", o_tvalid, (i == 1));
          if (arm_rst && o_tvalid && beat_cnt == 3) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk_zero("midrst");
            exp_q.delete();
            rst = 1'b0;
            did_rst = 1'b1;
            return;
          end
        end
      end
    end
  endtask

  // Downstream ready pattern generator.
  initial begin
    i_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_tready = 1'b1;
        1:       i_tready = 1'b0;
        default: i_tready = ~i_tready;
      endcase
    end
  end

  // Scoreboard: compare each transferred beat and each stalled beat with the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      beat_cnt = 0;
      run_cnt  = 0;
    end else begin
      if (o_overflow) ovf_cnt++;
      if (o_tvalid) run_cnt++;
      else          run_cnt = 0;
      if (o_tvalid && !i_tready && exp_q.size() > 0)
        chk("stall_hold", {o_tdata, o_tlast, o_tuser, o_line}, exp_q[0]);
      if (o_tvalid && i_tready) begin
        chk("beat_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beat_cnt), {o_tdata, o_tlast, o_tuser, o_line}, e);
        end
        if (o_tlast && bubble_en) chk("no_bubble_run", run_cnt, HW);
        beat_cnt = o_tlast ? 0 : beat_cnt + 1;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    i_pix_en = 1'b0;
    i_hsync  = 1'b0;
    i_vsync  = 1'b0;
    i_pixel  = 24'd0;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;

    // Two frames at full ready with h replicated in R/G/B, plus latency check.
    bubble_en = 1'b1;
    drive_frame(0, 0, 1'b1, 1'b1, 1'b0, dr);
    drive_frame(0, 1, 1'b1, 1'b0, 1'b0, dr);
    idle(30);
    chk("q_empty_plan", exp_q.size(), 0);
    chk("ovf_plan", ovf_cnt, 0);

    // Colour conversion constants.
    drive_frame(1, 2, 1'b1, 1'b0, 1'b0, dr);
    idle(30);
    chk("q_empty_conv", exp_q.size(), 0);
    bubble_en = 1'b0;

    // Downstream held off across four lines: two kept, two dropped.
    ready_mode = 1;
    idle(2);
    ovf_cnt = 0;
    drive_frame(2, 3, 1'b1, 1'b0, 1'b0, dr);
    drive_frame(2, 4, 1'b0, 1'b0, 1'b0, dr);
    chk("held_beats", exp_q.size(), 2 * HW);
    chk("ovf_drops", ovf_cnt, 2);
    ready_mode = 0;
    idle(40);
    chk("q_empty_hold", exp_q.size(), 0);

    // Ready toggling every clock.
    ready_mode = 2;
    drive_frame(2, 5, 1'b1, 1'b0, 1'b0, dr);
    idle(60);
    chk("q_empty_toggle", exp_q.size(), 0);
    ready_mode = 0;
    idle(2);

    // Reset at beat 3, then a clean frame.
    ovf_cnt = 0;
    drive_frame(2, 6, 1'b1, 1'b0, 1'b1, dr);
    chk("rst_taken", dr, 1);
    drive_frame(2, 7, 1'b1, 1'b0, 1'b0, dr);
    idle(30);
    chk("q_empty_after_rst", exp_q.size(), 0);
    chk("ovf_after_rst", ovf_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
